// File: rtl/usb_tx_packetizer.sv
module usb_tx_packetizer #(
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_pid,
  input  logic       cmd_zlp,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err_pid,
`ifdef USB_TX_MAXLEN_EN
  output logic       err_overlen,
`endif
  output logic       err_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC0,
    S_CRC1,
    S_FLUSH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_pid;
  logic        r_is_data;
  logic        r_zlp;
  logic [15:0] r_crc;
  logic [15:0] w_crc_next;
  logic        r_err_pid;
  logic        r_err_underrun;
  logic        w_is_hs;
  logic        w_is_data;
  logic        w_len_hit;

`ifdef USB_TX_MAXLEN_EN
  logic [10:0] r_cnt;
  logic        r_overlen;
  logic        r_err_overlen;

  assign w_len_hit   = (r_cnt == 11'(MAX_PAYLOAD - 1)) && !pl_last;
  assign err_overlen = r_err_overlen;
`else
  assign w_len_hit = 1'b0;
`endif

  assign busy         = (r_state != S_IDLE);
  assign err_pid      = r_err_pid;
  assign err_underrun = r_err_underrun;

  always_comb begin
    w_is_hs   = 1'b0;
    w_is_data = 1'b0;
    case (cmd_pid)
      4'b0010, 4'b1010, 4'b1110, 4'b0110: w_is_hs   = 1'b1;
      4'b0011, 4'b1011, 4'b0111, 4'b1111: w_is_data = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_crc_next = r_crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_crc_next[0] ^ pl_data[i])
        w_crc_next = (w_crc_next >> 1) ^ 16'hA001;
      else
        w_crc_next = w_crc_next >> 1;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    pl_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid && (w_is_hs || w_is_data))
          w_next = S_PID;
      end
      S_PID: begin
        tx_valid = 1'b1;
        tx_data  = {~r_pid, r_pid};
        if (tx_ready) begin
          if (!r_is_data)
            w_next = S_IDLE;
          else if (r_zlp)
            w_next = S_CRC0;
          else
            w_next = S_DATA;
        end
      end
      S_DATA: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready && pl_valid;
        if (!pl_valid)
          w_next = S_FLUSH;
        else if (tx_ready && (pl_last || w_len_hit))
          w_next = S_CRC0;
      end
      S_CRC0: begin
        tx_valid = 1'b1;
        tx_data  = ~r_crc[7:0];
        if (tx_ready)
          w_next = S_CRC1;
      end
      S_CRC1: begin
        tx_valid = 1'b1;
        tx_data  = ~r_crc[15:8];
        if (tx_ready) begin
`ifdef USB_TX_MAXLEN_EN
          w_next = r_overlen ? S_FLUSH : S_IDLE;
`else
          w_next = S_IDLE;
`endif
        end
      end
      S_FLUSH: begin
        pl_ready = 1'b1;
        if (pl_valid && pl_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pid          <= '0;
      r_is_data      <= 1'b0;
      r_zlp          <= 1'b0;
      r_crc          <= '1;
      r_err_pid      <= 1'b0;
      r_err_underrun <= 1'b0;
`ifdef USB_TX_MAXLEN_EN
      r_cnt          <= '0;
      r_overlen      <= 1'b0;
      r_err_overlen  <= 1'b0;
`endif
    end else begin
      r_state        <= w_next;
      r_err_pid      <= 1'b0;
      r_err_underrun <= 1'b0;
`ifdef USB_TX_MAXLEN_EN
      r_err_overlen  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_is_hs || w_is_data) begin
              r_pid     <= cmd_pid;
              r_is_data <= w_is_data;
              r_zlp     <= cmd_zlp;
              r_crc     <= '1;
`ifdef USB_TX_MAXLEN_EN
              r_cnt     <= '0;
              r_overlen <= 1'b0;
`endif
            end else begin
              r_err_pid <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (!pl_valid) begin
            r_err_underrun <= 1'b1;
          end else if (tx_ready) begin
            r_crc <= w_crc_next;
`ifdef USB_TX_MAXLEN_EN
            r_cnt <= r_cnt + 11'd1;
            if (w_len_hit) begin
              r_overlen     <= 1'b1;
              r_err_overlen <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
